// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults, clog2 helper and configuration check for sync_fifo
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_FIFO_DEPTH = 16;
  localparam int DEFAULT_ADDR_WIDTH = 4;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Depth must be a power of two matching the address width; flag levels inside 0..depth.
  function automatic bit fifo_cfg_ok(input int depth, input int addr_w, input int af, input int ae);
    return (depth >= 2) && (depth == (1 << addr_w)) && (clog2(depth) == addr_w) &&
           (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// rtl/sync_fifo_mem.sv - depth x width register array with registered read port
module sync_fifo_mem
  import fifo_pkg::*;
#(
  parameter int Data_Width = DEFAULT_DATA_WIDTH,
  parameter int Depth      = DEFAULT_FIFO_DEPTH,
  parameter int Addr_Width = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [Addr_Width-1:0] waddr_i,
  input  logic [Data_Width-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [Addr_Width-1:0] raddr_i,
  output logic [Data_Width-1:0] rdata_o
);

  logic [Data_Width-1:0] mem_q [Depth];
  logic [Data_Width-1:0] rdata_q;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with count, almost flags, read strobe; SYNC_FIFO_ERR_FLAGS_EN adds OVERFLOW/UNDERFLOW
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int Data_Width = DEFAULT_DATA_WIDTH,
  parameter int FIFO_Depth = DEFAULT_FIFO_DEPTH,
  parameter int Addr_Width = DEFAULT_ADDR_WIDTH,
  parameter int AF_Level   = 12,
  parameter int AE_Level   = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  W_INC,
  input  logic [Data_Width-1:0] WR_DATA,
  input  logic                  R_INC,
  output logic [Data_Width-1:0] RD_DATA,
  output logic                  RD_VALID,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  ALMOST_FULL,
  output logic                  ALMOST_EMPTY,
  output logic [Addr_Width:0]   COUNT
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
`endif
);

  typedef logic [Addr_Width:0] ptr_t;

  localparam bit   CFG_OK  = fifo_cfg_ok(FIFO_Depth, Addr_Width, AF_Level, AE_Level);
  localparam ptr_t DEPTH_C = ptr_t'(FIFO_Depth);
  localparam ptr_t AF_C    = ptr_t'(AF_Level);
  localparam ptr_t AE_C    = ptr_t'(AE_Level);
  localparam ptr_t ONE_C   = ptr_t'(1);

  if (!CFG_OK) begin : g_cfg_err
    $error("sync_fifo: illegal depth/address width/flag level combination");
  end

  ptr_t wptr_q, wptr_d;
  ptr_t rptr_q, rptr_d;
  ptr_t count_q, count_d;
  logic full_q, full_d;
  logic empty_q, empty_d;
  logic afull_q, afull_d;
  logic aempty_q, aempty_d;
  logic rd_valid_q;
  logic wr_acc;
  logic rd_acc;

  // Requests arriving with reset are ignored so the memory sees no stray write.
  assign wr_acc = W_INC & ~full_q & ~RST;
  assign rd_acc = R_INC & ~empty_q & ~RST;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_acc) begin
      wptr_d = wptr_q + ONE_C;
    end
    if (rd_acc) begin
      rptr_d = rptr_q + ONE_C;
    end
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
  end

  // Flags come from the next count, so they are registered with no path from the requests.
  always_comb begin
    full_d   = (count_d == DEPTH_C);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= AF_C);
    aempty_d = (count_d <= AE_C);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      afull_q    <= 1'b0;
      aempty_q   <= 1'b1;
      rd_valid_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      afull_q    <= afull_d;
      aempty_q   <= aempty_d;
      rd_valid_q <= rd_acc;
    end
  end

  sync_fifo_mem #(
    .Data_Width (Data_Width),
    .Depth      (FIFO_Depth),
    .Addr_Width (Addr_Width)
  ) u_mem (
    .clk_i   (CLK),
    .rst_i   (RST),
    .we_i    (wr_acc),
    .waddr_i (wptr_q[Addr_Width-1:0]),
    .wdata_i (WR_DATA),
    .re_i    (rd_acc),
    .raddr_i (rptr_q[Addr_Width-1:0]),
    .rdata_o (RD_DATA)
  );

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q;
  logic underflow_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_q | (W_INC & full_q);
      underflow_q <= underflow_q | (R_INC & empty_q);
    end
  end

  assign OVERFLOW  = overflow_q;
  assign UNDERFLOW = underflow_q;
`endif

  assign RD_VALID     = rd_valid_q;
  assign FULL         = full_q;
  assign EMPTY        = empty_q;
  assign ALMOST_FULL  = afull_q;
  assign ALMOST_EMPTY = aempty_q;
  assign COUNT        = count_q;

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock, parametrised FIFO for the same-domain data paths in the system, e.g. the register-file to UART-TX staging path.
- Generalises the existing 8x8 FIFO in data width, depth and status outputs: adds occupancy count, programmable almost-full/almost-empty flags and a read-valid strobe.
- Gray pointers and synchronisers are not used; all logic sits on one clock.

Parameters:
- Data_Width, 8, width of each stored word.
- FIFO_Depth, 16, number of entries; must be a power of two, minimum 2.
- Addr_Width, 4, log2(FIFO_Depth); pointers are Addr_Width+1 bits.
- AF_Level, 12, ALMOST_FULL asserts when COUNT >= AF_Level; legal range 1..FIFO_Depth.
- AE_Level, 2, ALMOST_EMPTY asserts when COUNT <= AE_Level; legal range 0..FIFO_Depth-1.

Ports:
- CLK  input  1  FIFO clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- W_INC  input  1  write request.
- WR_DATA  input  Data_Width  write data, sampled when a write is accepted.
- R_INC  input  1  read request.
- RD_DATA  output  Data_Width  registered read data.
- RD_VALID  output  1  one-cycle strobe; RD_DATA is valid in this cycle.
- FULL  output  1  COUNT == FIFO_Depth.
- EMPTY  output  1  COUNT == 0.
- ALMOST_FULL  output  1  COUNT >= AF_Level.
- ALMOST_EMPTY  output  1  COUNT <= AE_Level.
- COUNT  output  Addr_Width+1  current occupancy, 0..FIFO_Depth.

Behaviour:
- One clock (CLK). Reset (RST) is synchronous and active-high.
- Reset values:
  - Pointers = 0, COUNT = 0, EMPTY = 1, FULL = 0, ALMOST_EMPTY = 1, ALMOST_FULL = 0, RD_DATA = 0, RD_VALID = 0.
  - Memory contents are not reset.
- Accept rules, evaluated on pre-edge state:
  - WR_ACC = W_INC & !FULL.
  - RD_ACC = R_INC & !EMPTY.
- Accepted write: mem[WPTR[Addr_Width-1:0]] <= WR_DATA; WPTR increments mod 2*FIFO_Depth.
- Accepted read:
  - RD_DATA <= mem[RPTR[Addr_Width-1:0]]; RPTR increments.
  - RD_VALID = 1 in the following cycle (latency 1).
  - RD_DATA holds its value when no read is accepted.
- COUNT update:
  - +1 on WR_ACC only.
  - -1 on RD_ACC only.
  - Unchanged on both or neither.
- All flags are registered, derived from the next COUNT, so they are valid the cycle after the causing edge. No combinational path from W_INC/R_INC to flags.
- Boundary cases:
  - Full with W_INC & R_INC: read accepted, write dropped; COUNT = FIFO_Depth-1.
  - Empty with W_INC & R_INC: write accepted, read dropped; COUNT = 1, RD_VALID = 0. No fall-through.
  - Pointer wrap: address bits wrap at FIFO_Depth. FULL/EMPTY never derive from pointer MSB comparison alone; COUNT is authoritative and must equal WPTR-RPTR modulo 2*FIFO_Depth.
  - W_INC while FULL: no state change.
  - R_INC while EMPTY: no state change.
  - RST mid-operation: all state returns to reset values on the same edge; requests in that cycle are ignored.

Optional Feature:
- Macro: SYNC_FIFO_ERR_FLAGS_EN.
- When defined, adds two outputs:
  - OVERFLOW (1): sticky, set on any edge with W_INC & FULL.
  - UNDERFLOW (1): sticky, set on any edge with R_INC & EMPTY.
  - Both clear only on RST and are 0 after reset.
- When undefined, both ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package fifo_pkg holds:
  - default Data_Width/FIFO_Depth/Addr_Width constants;
  - a clog2 helper function;
  - localparam checks (FIFO_Depth == 2**Addr_Width, AF/AE ranges).
- One sub-module, sync_fifo_mem:
  - Depth x width register array with write enable, write address, read enable, read address and registered read-data output.
  - Pointer, count and flag logic stay in sync_fifo.

Test Plan:
- Reset then fill: RST 2 cycles, write 0x01..0x10 (16 words) → COUNT reaches 16, FULL = 1 and ALMOST_FULL = 1 one cycle after the 16th write, ALMOST_FULL first high after the 12th write.
- Drain: from full, R_INC held 16 cycles → RD_DATA 0x01..0x10 in order with RD_VALID each cycle, 1-cycle latency; EMPTY = 1 after the last read; ALMOST_EMPTY high once COUNT <= 2.
- Simultaneous at boundaries:
  - Full + W_INC + R_INC → COUNT 15, the dropped word is never read back.
  - Empty + both → COUNT 1, RD_VALID stays 0.
- Wrap-around: 40 cycles of random interleaved accepted writes/reads with COUNT between 3 and 10 → output order matches a scoreboard across 2+ pointer wraps; COUNT matches the model every cycle.
- Reset mid-stream: RST asserted with COUNT = 7 and W_INC/R_INC high → next cycle COUNT = 0, EMPTY = 1, RD_VALID = 0; a subsequent write of 0xA5 reads back as 0xA5.
- With SYNC_FIFO_ERR_FLAGS_EN: write while FULL → OVERFLOW = 1 and stays high through normal traffic until RST; read while EMPTY → UNDERFLOW = 1; FIFO contents unaffected.
